// File: rtl/ariane_regfile_scrub_if.sv
// Port bundle of the parity-protected integer register file: read, commit-write,
// fault-injection and scrub-error reporting signals.
interface ariane_regfile_scrub_if #(
   parameter int unsigned DATA_WIDTH     = 64,
   parameter int unsigned ADDR_WIDTH     = 5,
   parameter int unsigned NR_READ_PORTS  = 2,
   parameter int unsigned NR_WRITE_PORTS = 2
);
   logic [NR_READ_PORTS-1:0][ADDR_WIDTH-1:0]  raddr_i;
   logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o;
   logic [NR_READ_PORTS-1:0]                  rerr_o;
   logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] waddr_i;
   logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
   logic [NR_WRITE_PORTS-1:0]                 we_i;
   logic                                      inj_valid_i;
   logic [ADDR_WIDTH-1:0]                     inj_addr_i;
   logic [DATA_WIDTH-1:0]                     inj_mask_i;
   logic                                      scrub_en_i;
   logic                                      err_valid_o;
   logic [ADDR_WIDTH-1:0]                     err_addr_o;
   logic                                      err_ack_i;
   logic [7:0]                                err_count_o;

   modport master (
      output raddr_i, waddr_i, wdata_i, we_i, inj_valid_i, inj_addr_i, inj_mask_i,
             scrub_en_i, err_ack_i,
      input  rdata_o, rerr_o, err_valid_o, err_addr_o, err_count_o
   );

   modport slave (
      input  raddr_i, waddr_i, wdata_i, we_i, inj_valid_i, inj_addr_i, inj_mask_i,
             scrub_en_i, err_ack_i,
      output rdata_o, rerr_o, err_valid_o, err_addr_o, err_count_o
   );
endinterface

// File: rtl/ariane_regfile_scrub.sv
// FF register file with per-word even parity, prioritised write ports and a background scrub engine.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_WR_BYPASS_EN.
module ariane_regfile_scrub #(
   parameter int unsigned DATA_WIDTH     = 64,
   parameter int unsigned ADDR_WIDTH     = 5,
   parameter int unsigned NR_READ_PORTS  = 2,
   parameter int unsigned NR_WRITE_PORTS = 2,
   parameter bit          ZERO_REG_ZERO  = 1'b1,
   parameter int unsigned SCRUB_INTERVAL = 16
) (
   input logic                   clk_i,
   input logic                   rst_ni,
   ariane_regfile_scrub_if.slave bus
);
   localparam int unsigned NUM_WORDS = 2**ADDR_WIDTH;
   localparam int unsigned CNT_W     = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
   localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(ZERO_REG_ZERO ? 1 : 0);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_REPORT} state_e;

   logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]    mem;
   logic [NUM_WORDS-1:0]                    par;
   logic [NR_WRITE_PORTS-1:0]               wr_ok;
   logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0] rdata;
   logic [NR_READ_PORTS-1:0]                rerr;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, ptr_next;
   logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
   logic [7:0]            err_cnt_q, err_cnt_d;
   logic                  ptr_wr_hit, ptr_bad;

   always_comb begin
      for (int p = 0; p < NR_WRITE_PORTS; p++) begin
         wr_ok[p] = bus.we_i[p] && !(ZERO_REG_ZERO && (bus.waddr_i[p] == '0));
      end
   end

   // Later non-blocking assignments win: writes override an injection, higher ports override lower.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem <= '0;
         par <= '0;
      end else begin
         if (bus.inj_valid_i && !(ZERO_REG_ZERO && (bus.inj_addr_i == '0))) begin
            mem[bus.inj_addr_i] <= mem[bus.inj_addr_i] ^ bus.inj_mask_i;
         end
         for (int p = 0; p < NR_WRITE_PORTS; p++) begin
            if (wr_ok[p]) begin
               mem[bus.waddr_i[p]] <= bus.wdata_i[p];
               par[bus.waddr_i[p]] <= ^bus.wdata_i[p];
            end
         end
      end
   end

   always_comb begin
      rdata = '0;
      rerr  = '0;
      for (int r = 0; r < NR_READ_PORTS; r++) begin
         rdata[r] = mem[bus.raddr_i[r]];
         rerr[r]  = (^mem[bus.raddr_i[r]]) != par[bus.raddr_i[r]];
`ifdef REGFILE_WR_BYPASS_EN
         for (int p = 0; p < NR_WRITE_PORTS; p++) begin
            if (wr_ok[p] && (bus.waddr_i[p] == bus.raddr_i[r])) begin
               rdata[r] = bus.wdata_i[p];
               rerr[r]  = 1'b0;
            end
         end
`endif
         if (ZERO_REG_ZERO && (bus.raddr_i[r] == '0)) begin
            rdata[r] = '0;
            rerr[r]  = 1'b0;
         end
      end
   end

   assign bus.rdata_o = rdata;
   assign bus.rerr_o  = rerr;

   always_comb begin
      ptr_wr_hit = 1'b0;
      for (int p = 0; p < NR_WRITE_PORTS; p++) begin
         if (wr_ok[p] && (bus.waddr_i[p] == ptr_q)) ptr_wr_hit = 1'b1;
      end
      ptr_bad  = (^mem[ptr_q]) != par[ptr_q];
      ptr_next = (ptr_q == LAST_ADDR) ? FIRST_ADDR : ptr_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         ptr_q      <= FIRST_ADDR;
         err_addr_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         err_addr_q <= err_addr_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ptr_d      = ptr_q;
      err_addr_d = err_addr_q;
      err_cnt_d  = err_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.scrub_en_i) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            if (!bus.scrub_en_i) state_d = S_IDLE;
            else if (cnt_q == CNT_W'(SCRUB_INTERVAL - 1)) state_d = S_CHECK;
            else cnt_d = cnt_q + 1'b1;
         end
         S_CHECK: begin
            // A word being rewritten this cycle is not judged on its stale contents.
            if (ptr_bad && !ptr_wr_hit) begin
               state_d    = S_REPORT;
               err_addr_d = ptr_q;
               if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end else begin
               ptr_d   = ptr_next;
               cnt_d   = '0;
               state_d = bus.scrub_en_i ? S_WAIT : S_IDLE;
            end
         end
         S_REPORT: begin
            if (bus.err_ack_i) begin
               ptr_d   = ptr_next;
               cnt_d   = '0;
               state_d = bus.scrub_en_i ? S_WAIT : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.err_valid_o = (state_q == S_REPORT);
   assign bus.err_addr_o  = err_addr_q;
   assign bus.err_count_o = err_cnt_q;
endmodule

// File: tb/tb_ariane_regfile_scrub.sv
// Scoreboard bench: stimulus queues expected read/status/scrub-error results, a monitor
// compares them whenever the corresponding DUT response is presented.
module tb_ariane_regfile_scrub;
   logic clk_i;
   logic rst_ni;

   ariane_regfile_scrub_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NR_READ_PORTS(2), .NR_WRITE_PORTS(2)) bus ();

   ariane_regfile_scrub #(
      .DATA_WIDTH(64), .ADDR_WIDTH(5), .NR_READ_PORTS(2), .NR_WRITE_PORTS(2),
      .ZERO_REG_ZERO(1'b1), .SCRUB_INTERVAL(16)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   typedef struct { logic [63:0] data; logic err; } rd_exp_t;
   typedef struct { logic [4:0] addr; logic [7:0] cnt; } err_exp_t;
   typedef struct { logic valid; logic chk_addr; logic [4:0] addr; logic [7:0] cnt; } st_exp_t;

   rd_exp_t  rd_q[$];
   err_exp_t err_q[$];
   st_exp_t  st_q[$];
   logic     rd_chk, st_chk, err_prev;
   int       n_chk, n_fail;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: samples on the falling edge, inputs change just after the rising edge.
   initial begin
      rd_exp_t  re;
      err_exp_t ee;
      st_exp_t  se;
      err_prev = 1'b0;
      forever begin
         @(negedge clk_i);
         if (rd_chk) begin
            if (rd_q.size() == 0) check("rd_queue_empty", 64'd1, 64'd0);
            else begin
               re = rd_q.pop_front();
               for (int r = 0; r < 2; r++) begin
                  check($sformatf("rdata[%0d] a=%0d", r, bus.raddr_i[r]), bus.rdata_o[r], re.data);
                  check($sformatf("rerr[%0d] a=%0d", r, bus.raddr_i[r]), 64'(bus.rerr_o[r]), 64'(re.err));
               end
            end
         end
         if (st_chk) begin
            if (st_q.size() == 0) check("st_queue_empty", 64'd1, 64'd0);
            else begin
               se = st_q.pop_front();
               check("err_valid", 64'(bus.err_valid_o), 64'(se.valid));
               check("err_count", 64'(bus.err_count_o), 64'(se.cnt));
               if (se.chk_addr) check("err_addr", 64'(bus.err_addr_o), 64'(se.addr));
            end
         end
         if (bus.err_valid_o && !err_prev) begin
            if (err_q.size() == 0) check("unexpected_scrub_err addr", 64'(bus.err_addr_o), 64'hFFFF);
            else begin
               ee = err_q.pop_front();
               check("scrub_err_addr", 64'(bus.err_addr_o), 64'(ee.addr));
               check("scrub_err_count", 64'(bus.err_count_o), 64'(ee.cnt));
            end
         end
         err_prev = bus.err_valid_o;
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
      bus.we_i        = '0;
      bus.inj_valid_i = 1'b0;
      bus.err_ack_i   = 1'b0;
      rd_chk          = 1'b0;
      st_chk          = 1'b0;
   endtask

   task automatic rd_check(input logic [4:0] a, input logic [63:0] d, input logic e);
      rd_exp_t x;
      x.data = d;
      x.err  = e;
      bus.raddr_i[0] = a;
      bus.raddr_i[1] = a;
      rd_q.push_back(x);
      rd_chk = 1'b1;
      step();
   endtask

   task automatic st_check(input logic v, input logic ca, input logic [4:0] a, input logic [7:0] c);
      st_exp_t x;
      x.valid = v; x.chk_addr = ca; x.addr = a; x.cnt = c;
      st_q.push_back(x);
      st_chk = 1'b1;
      step();
   endtask

   task automatic set_wr(input int p, input logic [4:0] a, input logic [63:0] d);
      bus.we_i[p]    = 1'b1;
      bus.waddr_i[p] = a;
      bus.wdata_i[p] = d;
   endtask

   task automatic set_inj(input logic [4:0] a, input logic [63:0] m);
      bus.inj_valid_i = 1'b1;
      bus.inj_addr_i  = a;
      bus.inj_mask_i  = m;
   endtask

   task automatic push_err(input logic [4:0] a, input logic [7:0] c);
      err_exp_t x;
      x.addr = a;
      x.cnt  = c;
      err_q.push_back(x);
   endtask

   task automatic wait_err(input int bound, input string name);
      for (int c = 0; c < bound && !bus.err_valid_o; c++) step();
      if (!bus.err_valid_o) check({"timeout_", name}, 64'd0, 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0; n_fail = 0;
      rd_chk = 1'b0; st_chk = 1'b0;
      rst_ni = 1'b0;
      bus.raddr_i = '0; bus.waddr_i = '0; bus.wdata_i = '0; bus.we_i = '0;
      bus.inj_valid_i = 1'b0; bus.inj_addr_i = '0; bus.inj_mask_i = '0;
      bus.scrub_en_i = 1'b0; bus.err_ack_i = 1'b0;
      step();
      st_check(1'b0, 1'b1, 5'd0, 8'd0);
      rst_ni = 1'b1;
      step();
      rd_check(5'd5, 64'd0, 1'b0);

      // Basic write, port priority and hardwired zero register.
      set_wr(0, 5'd5, 64'hDEAD_BEEF_0000_0001);
      step();
      rd_check(5'd5, 64'hDEAD_BEEF_0000_0001, 1'b0);
      set_wr(0, 5'd7, 64'h11);
      set_wr(1, 5'd7, 64'h22);
      step();
      rd_check(5'd7, 64'h22, 1'b0);
      set_wr(1, 5'd0, 64'hFF);
      step();
      rd_check(5'd0, 64'd0, 1'b0);

      // Same-cycle read of a word being written.
      set_wr(0, 5'd12, 64'hABC);
`ifdef REGFILE_WR_BYPASS_EN
      rd_check(5'd12, 64'hABC, 1'b0);
`else
      rd_check(5'd12, 64'd0, 1'b0);
`endif
      rd_check(5'd12, 64'hABC, 1'b0);

      // Injection corrupts data without touching parity; a same-cycle write cancels it.
      set_wr(0, 5'd3, 64'h5);
      step();
      set_inj(5'd3, 64'h1);
      step();
      rd_check(5'd3, 64'h4, 1'b1);
      set_inj(5'd9, 64'hF0);
      set_wr(1, 5'd9, 64'h77);
      step();
      rd_check(5'd9, 64'h77, 1'b0);

      // Scrub finds x3, holds until ack, then resumes at x4.
      push_err(5'd3, 8'd1);
      bus.scrub_en_i = 1'b1;
      wait_err(200, "x3");
      step(); step(); step();
      st_check(1'b1, 1'b1, 5'd3, 8'd1);
      bus.err_ack_i = 1'b1;
      step();
      st_check(1'b0, 1'b0, 5'd0, 8'd1);
      set_inj(5'd4, 64'h1);
      push_err(5'd4, 8'd2);
      step();
      wait_err(20, "x4");
      bus.err_ack_i = 1'b1;
      step();
      set_wr(0, 5'd3, 64'h5);
      set_wr(1, 5'd4, 64'h0);
      step();

      // Clean sweep (x9 included); stray acks while nothing is pending are ignored.
      for (int c = 0; c < 600; c++) begin
         if (c % 50 == 7) bus.err_ack_i = 1'b1;
         step();
      end
      st_check(1'b0, 1'b0, 5'd0, 8'd2);

      // Reset while an error is pending drops it and clears the count.
      set_inj(5'd6, 64'h8000_0000_0000_0000);
      push_err(5'd6, 8'd3);
      step();
      wait_err(1200, "x6");
      step();
      st_check(1'b1, 1'b1, 5'd6, 8'd3);
      bus.scrub_en_i = 1'b0;
      rst_ni = 1'b0;
      st_check(1'b0, 1'b1, 5'd0, 8'd0);
      rst_ni = 1'b1;
      step();
      rd_check(5'd6, 64'd0, 1'b0);

      // Corrupt every scannable word; nine sweeps saturate the counter and show the 31->1 wrap.
      for (int a = 1; a < 32; a++) begin
         set_inj(5'(a), 64'h1);
         step();
      end
      rd_check(5'd31, 64'h1, 1'b1);
      for (int n = 1; n <= 279; n++) push_err(5'(((n - 1) % 31) + 1), 8'((n > 255) ? 255 : n));
      bus.scrub_en_i = 1'b1;
      for (int n = 1; n <= 279; n++) begin
         wait_err(40, "sweep");
         bus.err_ack_i = 1'b1;
         step();
      end
      bus.scrub_en_i = 1'b0;
      step();
      st_check(1'b0, 1'b0, 5'd0, 8'd255);

      step(); step();
      check("rd_queue_drained", 64'(rd_q.size()), 64'd0);
      check("err_queue_drained", 64'(err_q.size()), 64'd0);
      check("st_queue_drained", 64'(st_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
